// File: rtl/apb4_master_bridge.sv
// APB4 requester bridge: turns a valid/ready command stream into single APB4
// transfers and returns each result on a valid/ready response stream.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
//   ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
//   RESP   | rsp_valid high until rsp_ready
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int CNT_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cmd_fire;
    logic             done_ok;
    logic             done_to;

    assign cmd_ready = (state == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign done_ok   = (state == ACCESS) && PREADY;
    // PREADY takes priority over a timeout landing in the same cycle.
    assign done_to   = TO_EN && (state == ACCESS) && !PREADY && (cnt == CNT_LAST);

    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done_ok || done_to) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (cmd_fire) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PSTRB  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                PPROT  <= cmd_prot;
            end
            if (state == SETUP) begin
                cnt <= '0;
            end else if ((state == ACCESS) && !PREADY) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (done_ok) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (done_to) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge with a behavioural APB completer
// and a transfer-level reference model of expected cycles and responses.
module tb_apb4_master_bridge;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          cmd_write = 1'b0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_strb = '0;
   logic [2:0]    cmd_prot = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          PSEL;
   logic          PENABLE;
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic [3:0]    PSTRB;
   logic [2:0]    PPROT;
   logic          PREADY = 1'b0;
   logic [DW-1:0] PRDATA = '0;
   logic          PSLVERR = 1'b0;

   int checks   = 0;
   int failures = 0;

   // completer configuration: ready after c_waits wait states
   int            c_waits = 0;
   logic [DW-1:0] c_rdata = '0;
   logic          c_err   = 1'b0;
   int            acc_n   = 0;

   apb4_master_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_write  (cmd_write),
      .cmd_wdata  (cmd_wdata),
      .cmd_strb   (cmd_strb),
      .cmd_prot   (cmd_prot),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PADDR      (PADDR),
      .PWRITE     (PWRITE),
      .PWDATA     (PWDATA),
      .PSTRB      (PSTRB),
      .PPROT      (PPROT),
      .PREADY     (PREADY),
      .PRDATA     (PRDATA),
      .PSLVERR    (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Completer: garbage on PREADY/PRDATA/PSLVERR outside the completing cycle.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         acc_n   = acc_n + 1;
         PREADY  = (acc_n == c_waits + 1);
         PRDATA  = PREADY ? c_rdata : $urandom;
         PSLVERR = PREADY ? c_err : 1'($urandom);
      end else begin
         acc_n   = 0;
         PREADY  = 1'($urandom);
         PRDATA  = $urandom;
         PSLVERR = 1'($urandom);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: sim time expired, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT} !== '0) begin
         failures++;
         $display("FAIL reset_apb: got sel=%b en=%b addr=%h, required all zero", PSEL, PENABLE, PADDR);
      end
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
         failures++;
         $display("FAIL reset_rsp: got v=%b d=%h e=%b t=%b, required all zero", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      end
      PRESETn = 1'b1;
      @(negedge PCLK);
   endtask

   // One transfer from an IDLE negedge back to an IDLE negedge.
   task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic [DW-1:0] rd, input logic er, input int rdelay);
      int            exp_acc;
      logic          exp_to;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      logic [3:0]    exp_strb;
      int            acc;
      exp_to    = (waits + 1) > TMO;
      exp_acc   = exp_to ? TMO : waits + 1;
      exp_rdata = (w || exp_to) ? '0 : rd;
      exp_err   = exp_to || er;
      exp_strb  = w ? st : 4'h0;
      c_waits = waits; c_rdata = rd; c_err = er;
      cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ready_idle: got %b required 1", cmd_ready);
      end
      @(negedge PCLK);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
      checks++;
      if ({PSEL, PENABLE} !== 2'b10) begin
         failures++;
         $display("FAIL setup_phase: got sel/en=%b required 10", {PSEL, PENABLE});
      end
      checks++;
      if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !== {a, w, wd, exp_strb, pr}) begin
         failures++;
         $display("FAIL setup_fields: got %h/%b/%h/%h/%h required %h/%b/%h/%h/%h",
                  PADDR, PWRITE, PWDATA, PSTRB, PPROT, a, w, wd, exp_strb, pr);
      end
      @(negedge PCLK);
      acc = 0;
      while (PSEL && PENABLE && acc < 40) begin
         acc++;
         checks++;
         if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT, cmd_ready} !== {a, w, wd, exp_strb, pr, 1'b0}) begin
            failures++;
            $display("FAIL access_fields: cycle %0d got addr=%h strb=%h rdy=%b required addr=%h strb=%h rdy=0",
                     acc, PADDR, PSTRB, cmd_ready, a, exp_strb);
         end
         cmd_valid = 1'($urandom);
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      checks++;
      if (acc != exp_acc) begin
         failures++;
         $display("FAIL access_cycles: got %0d required %0d", acc, exp_acc);
      end
      checks++;
      if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin
         failures++;
         $display("FAIL rsp_phase: got v/sel/en=%b required 100", {rsp_valid, PSEL, PENABLE});
      end
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, exp_err, exp_to}) begin
         failures++;
         $display("FAIL rsp_fields: got d=%h e=%b t=%b required d=%h e=%b t=%b",
                  rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, exp_to);
      end
      for (int i = 0; i < rdelay; i++) begin
         @(negedge PCLK);
         checks++;
         if ({rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout} !== {2'b10, exp_rdata, exp_err, exp_to}) begin
            failures++;
            $display("FAIL rsp_hold: got v=%b rdy=%b d=%h e=%b t=%b required v=1 rdy=0 d=%h e=%b t=%b",
                     rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, exp_to);
         end
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL rsp_release: got v/rdy=%b required 01", {rsp_valid, cmd_ready});
      end
   endtask

   task automatic test_write_zero_wait();
      run_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, $urandom, 1'b0, 0);
   endtask

   task automatic test_read_waits();
      run_xfer(32'h0000_0020, 1'b0, $urandom, 4'hF, 3'b000, 3, 32'h1234_5678, 1'b0, 1);
   endtask

   task automatic test_slave_error();
      run_xfer(32'h0000_0300, 1'b1, 32'hCAFE_0001, 4'h3, 3'b001, 1, $urandom, 1'b1, 0);
      run_xfer(32'h0000_0304, 1'b0, '0, 4'h0, 3'b000, 0, 32'hA5A5_5A5A, 1'b0, 0);
   endtask

   task automatic test_timeout();
      run_xfer(32'h0000_0400, 1'b0, '0, 4'h0, 3'b000, 1000, 32'h1111_2222, 1'b0, 2);
      run_xfer(32'h0000_0404, 1'b0, '0, 4'h0, 3'b000, TMO - 1, 32'h3333_4444, 1'b0, 0);
      run_xfer(32'h0000_0408, 1'b1, 32'h5, 4'h1, 3'b100, TMO, 32'h0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      c_waits = 0; c_rdata = 32'h7777_8888; c_err = 1'b0;
      cmd_addr = 32'h40; cmd_write = 1'b1; cmd_wdata = 32'h0BAD_F00D; cmd_strb = 4'hC; cmd_prot = 3'b011;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      @(negedge PCLK);
      cmd_addr = 32'h80; cmd_write = 1'b0; cmd_prot = 3'b101;
      @(negedge PCLK);
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
         failures++;
         $display("FAIL b2b_first_rsp: got v=%b e=%b t=%b d=%h required 1/0/0/0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         checks++;
         if ({rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata} !== {4'b1000, 32'h0}) begin
            failures++;
            $display("FAIL b2b_backpressure: cycle %0d got v=%b rdy=%b sel=%b required 1/0/0", i, rsp_valid, cmd_ready, PSEL);
         end
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_idle_gap: got v/rdy/sel=%b required 010", {rsp_valid, cmd_ready, PSEL});
      end
      @(negedge PCLK);
      cmd_valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT} !== {2'b10, 32'h80, 1'b0, 4'h0, 3'b101}) begin
         failures++;
         $display("FAIL b2b_second_setup: got sel/en=%b addr=%h w=%b strb=%h prot=%h required 10 80 0 0 5",
                  {PSEL, PENABLE}, PADDR, PWRITE, PSTRB, PPROT);
      end
      @(negedge PCLK);
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h7777_8888, 1'b0}) begin
         failures++;
         $display("FAIL b2b_second_rsp: got v=%b d=%h e=%b required 1 77778888 0", rsp_valid, rsp_rdata, rsp_err);
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      c_waits = 1000;
      cmd_addr = 32'h900; cmd_write = 1'b1; cmd_wdata = 32'h99; cmd_strb = 4'hF; cmd_prot = 3'b111;
      cmd_valid = 1'b1;
      @(negedge PCLK);
      repeat (3) @(negedge PCLK);
      #2;
      PRESETn = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, rsp_valid, PADDR, PPROT, PSTRB} !== '0) begin
         failures++;
         $display("FAIL reset_async: got sel=%b en=%b v=%b addr=%h required all zero", PSEL, PENABLE, rsp_valid, PADDR);
      end
      repeat (2) @(negedge PCLK);
      checks++;
      if ({PSEL, rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL reset_no_accept: got sel/v=%b required 00", {PSEL, rsp_valid});
      end
      cmd_valid = 1'b0;
      PRESETn = 1'b1;
      @(negedge PCLK);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         checks++;
         if ({rsp_valid, PSEL} !== 2'b00) begin
            failures++;
            $display("FAIL reset_stale_rsp: cycle %0d got v/sel=%b required 00", i, {rsp_valid, PSEL});
         end
      end
   endtask

   task automatic test_random();
      int waits;
      for (int i = 0; i < 24; i++) begin
         waits = (i % 6 == 5) ? 500 : int'($urandom_range(0, 9));
         run_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                  waits, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_waits();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 requester (master) bridge. Converts a valid/ready command stream into single APB4 transfers and returns each result on a valid/ready response stream.
- It is the requesting end of the APB4 interface whose completer side the slave VIP models. It lets that VIP be driven by RTL rather than by a class-based driver.
- One transfer is outstanding at a time. A programmable timeout terminates transfers whose PREADY never arrives.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata. Legal values: 8, 16, 32.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for PREADY. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled, or timeout.
- rsp_timeout  out  1  transfer terminated by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PPROT  out  3  APB protection.
- PREADY  in  1  completer ready.
- PRDATA  in  DATA_WIDTH  completer read data.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset: PRESETn low forces the following immediately, regardless of PCLK:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT = 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0.
  - timeout counter = 0.
- Reset mid-transfer: the transfer is abandoned with no response. No command is accepted while PRESETn is low.
- cmd_ready is combinational and equals (state==IDLE). It never depends on cmd_valid.
- FSM states:
  - IDLE: on cmd_valid&&cmd_ready, register addr/write/wdata/prot, and strb (forced to 0 when cmd_write=0). Go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, exactly one cycle. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. The counter increments each cycle PREADY=0.
    - On PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0. Drop PSEL/PENABLE next cycle and go to RESP.
    - Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: rsp_err=1, rsp_timeout=1, rsp_rdata=0. Drop PSEL/PENABLE and go to RESP.
  - RESP: rsp_valid=1, PSEL=PENABLE=0. On rsp_ready go to IDLE and clear rsp_valid.
- Response fields stay stable while rsp_valid=1 and rsp_ready=0.
- PSLVERR and PRDATA are ignored except in the cycle PSEL&PENABLE&PREADY.
- Latency with no wait states and rsp_ready held 1:
  - Command accepted at edge N.
  - SETUP during N..N+1, ACCESS during N+1..N+2.
  - rsp_valid high N+2..N+3.
  - cmd_ready high again from edge N+3.
  - Throughput is 1 transfer per 4 cycles.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are constant from SETUP through the completing ACCESS cycle. They hold their last value while idle and are not zeroed.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP.
- Edge cases:
  - PREADY=1 in the same cycle the timeout threshold is hit: PREADY wins and the transfer is a normal completion.
  - PREADY/PSLVERR values outside ACCESS have no effect.
  - cmd_valid toggling while not ready has no effect.

Test Plan:
- Write, zero wait. Command addr=0x0000_1004, wdata=0xDEAD_BEEF, strb=0xF, prot=3'b010; completer PREADY=1.
  -> One SETUP then one ACCESS cycle with PADDR=0x1004, PWRITE=1, PSTRB=0xF, PPROT=2. rsp_valid 2 cycles after accept, with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states. Addr=0x20; completer returns PRDATA=0x1234_5678 on the 4th ACCESS cycle.
  -> PENABLE high for exactly 4 cycles, PSTRB=0, rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error. Write with PSLVERR=1 in the PREADY cycle.
  -> rsp_err=1, rsp_timeout=0. The next command starts normally.
- Timeout. TIMEOUT_CYCLES=8, PREADY held 0.
  -> PSEL drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. PREADY arriving on cycle 8 instead gives a normal completion.
- Backpressure/back-to-back. rsp_ready=0 for 5 cycles, with cmd_valid held high carrying a second command.
  -> Response stable, cmd_ready=0 throughout. The second SETUP begins 2 cycles after rsp handshake.
- Reset mid-ACCESS. PRESETn asserted during wait states.
  -> PSEL/PENABLE/rsp_valid fall to 0 asynchronously. After release, cmd_ready=1 and no stale response is produced.
